// File: rtl/timer8_pkg.sv
// Shared types and constants for the 8-bit interval timer controller.
package timer8_pkg;

    localparam int PERIOD_W = 8;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/timer8_cnt8_dp.sv
// 8-bit up-counter datapath: synchronous active-low reset, priority load, gated +1.
module cnt8_dp
    import timer8_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] load_val_i,
    input  logic                en_i,
    output logic [PERIOD_W-1:0] cnt_o
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/timer8_ctrl.sv
// Interval-timer controller: sequences cnt8_dp in one-shot or periodic mode,
// emits a registered terminal tick and accepts period updates applied at wrap.
module timer8_ctrl
    import timer8_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] start_period,
    input  logic                cfg_valid,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                cfg_ready,
    output logic [PERIOD_W-1:0] cnt,
    output logic                busy,
    output logic                tick
);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                mode_q, mode_d;
    logic [PERIOD_W-1:0] shadow_q, shadow_d;
    logic                pend_q, pend_d;
    logic                tick_q, tick_d;

    logic [PERIOD_W-1:0] term;
    logic                at_term;
    logic                xfer;
    logic                dp_load;
    logic                dp_en;

    // Period 0 wraps to term 0xFF, giving a 256-cycle interval.
    assign term    = period_q - 8'd1;
    assign at_term = (state_q == ST_RUN) && (cnt == term);

    assign cfg_ready = !pend_q && res;
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        shadow_d = xfer ? cfg_period : shadow_q;
        pend_d   = pend_q || xfer;
        tick_d   = 1'b0;
        dp_load  = 1'b0;
        dp_en    = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            dp_load = 1'b1;
        end else if (start) begin
            state_d  = ST_RUN;
            period_d = start_period;
            mode_d   = mode;
            pend_d   = 1'b0;
            dp_load  = 1'b1;
        end else if (at_term) begin
            tick_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
                dp_load = 1'b1;
                // xfer needs !pend_q, so a same-edge offer lands for the next wrap.
                if (pend_q) begin
                    period_d = shadow_q;
                    pend_d   = 1'b0;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_RUN) begin
            dp_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
        end
    end

    cnt8_dp u_dp (
        .clk_i      (clk),
        .rst_n_i    (res),
        .load_i     (dp_load),
        .load_val_i (8'h00),
        .en_i       (dp_en),
        .cnt_o      (cnt)
    );

    assign busy = (state_q == ST_RUN);
    assign tick = tick_q;

endmodule

// File: tb/tb_timer8_ctrl.sv
// Self-checking bench for timer8_ctrl: directed scenarios then random traffic,
// all checked against an integer-period reference model.
module tb_timer8_ctrl;

    logic       clk = 1'b0;
    logic       res, start, stop, mode, cfg_valid;
    logic [7:0] start_period, cfg_period;
    logic       cfg_ready, busy, tick;
    logic [7:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position within interval and interval length in 1..256.
    int m_pos, m_per, m_shadow;
    bit m_busy, m_tick, m_mode, m_pend;

    always #5 clk = ~clk;

    timer8_ctrl dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .start_period (start_period),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_ready    (cfg_ready),
        .cnt          (cnt),
        .busy         (busy),
        .tick         (tick)
    );

    function automatic int plen(input logic [7:0] p);
        return (p == 8'd0) ? 256 : int'(p);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cnt", int'(cnt), m_pos % 256);
        chk("busy", int'(busy), int'(m_busy));
        chk("tick", int'(tick), int'(m_tick));
        chk("cfg_ready", int'(cfg_ready), int'(!m_pend && res));
    endtask

    // Advance one clock edge, update the model with the inputs seen at that edge.
    task automatic step();
        bit xfer;
        bit pn;
        xfer = cfg_valid && !m_pend && res;
        @(posedge clk);
        if (!res) begin
            m_busy = 0; m_pos = 0; m_per = 256; m_mode = 0; m_pend = 0; m_tick = 0;
        end else if (stop) begin
            m_busy = 0; m_pos = 0; m_pend = 0; m_tick = 0;
        end else if (start) begin
            m_busy = 1; m_pos = 0; m_per = plen(start_period); m_mode = mode;
            m_pend = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            pn = m_pend;
            if (m_busy) begin
                if (m_pos + 1 == m_per) begin
                    m_tick = 1;
                    if (m_mode) begin
                        m_pos = 0;
                        if (m_pend) begin
                            m_per = m_shadow;
                            pn = 0;
                        end
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (xfer) begin
                m_shadow = plen(cfg_period);
                pn = 1;
            end
            m_pend = pn;
        end
        #1;
        check_all();
    endtask

    task automatic idle_in();
        start = 0; stop = 0; cfg_valid = 0;
    endtask

    initial begin
        int ticks;
        m_pos = 0; m_per = 256; m_shadow = 256;
        m_busy = 0; m_tick = 0; m_mode = 0; m_pend = 0;
        res = 0; start = 1; stop = 0; mode = 1; start_period = 8'd5;
        cfg_valid = 1; cfg_period = 8'd7;

        // Reset held with start/cfg asserted
        repeat (3) step();
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_ready", int'(cfg_ready), 0);
        res = 1; idle_in();
        #1;
        chk("post_rst_ready", int'(cfg_ready), 1);
        step();

        // Periodic P=5
        start = 1; mode = 1; start_period = 8'd5;
        step();
        idle_in();
        ticks = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (tick) ticks++;
            if (k % 5 == 0) chk("p5_tick_at", int'(tick), 1);
        end
        chk("p5_ticks", ticks, 3);
        chk("p5_busy", int'(busy), 1);

        // One-shot P=256
        start = 1; mode = 0; start_period = 8'd0;
        step();
        idle_in();
        ticks = 0;
        for (int k = 1; k <= 260; k++) begin
            step();
            if (tick) ticks++;
            if (k == 256) chk("os_tick_256", int'(tick), 1);
        end
        chk("os_ticks", ticks, 1);
        chk("os_hold", int'(cnt), 8'hFF);
        chk("os_busy", int'(busy), 0);

        // Period update offered on the first-wrap edge: 4 then 2
        start = 1; mode = 1; start_period = 8'd4;
        step();
        idle_in();
        repeat (3) step();
        cfg_valid = 1; cfg_period = 8'd2;
        step();
        chk("upd_wrap_tick", int'(tick), 1);
        cfg_valid = 0;
        chk("upd_ready_low", int'(cfg_ready), 0);
        repeat (3) step();
        chk("upd_ready_still_low", int'(cfg_ready), 0);
        step();
        chk("upd_second_wrap", int'(tick), 1);
        chk("upd_ready_back", int'(cfg_ready), 1);
        step();
        step();
        chk("upd_p2_wrap", int'(tick), 1);

        // start and stop together -> stop wins
        start = 1; stop = 1;
        step();
        idle_in();
        chk("ss_busy", int'(busy), 0);
        chk("ss_cnt", int'(cnt), 0);

        // Restart at cnt 3 with P=3 -> no tick
        start = 1; mode = 1; start_period = 8'd9;
        step();
        idle_in();
        repeat (3) step();
        start = 1; start_period = 8'd3;
        step();
        idle_in();
        chk("rs_tick", int'(tick), 0);
        chk("rs_cnt", int'(cnt), 0);

        // P=1 periodic ticks every cycle
        start = 1; start_period = 8'd1;
        step();
        idle_in();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("p1_tick", int'(tick), 1);
        end

        // Stop on the terminal edge
        stop = 1;
        step();
        idle_in();
        chk("stop_term_tick", int'(tick), 0);

        // Reset mid-run
        start = 1; start_period = 8'd6;
        step();
        idle_in();
        repeat (2) step();
        res = 0;
        step();
        chk("midrst_busy", int'(busy), 0);
        res = 1;
        step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            res          = ($urandom_range(0, 199) != 0);
            start        = ($urandom_range(0, 39) == 0);
            stop         = ($urandom_range(0, 79) == 0);
            mode         = $urandom_range(0, 1);
            start_period = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_period   = 8'($urandom_range(0, 10));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer8_ctrl.md
# timer8_ctrl

Programmable interval-timer controller that sequences an 8-bit loadable up-counter datapath. It runs the counter in one-shot or periodic mode, emits a one-cycle terminal-count tick, and accepts period updates while running over a valid/ready handshake that takes effect at the next wrap. It sits between a control master (CPU-style register block or FSM) and the 8-bit counter datapath.

## Interface
- PERIOD_W, 8: counter and period width (fixed at 8 for this block).
- clk  in  1  rising-edge clock; the only clock.
- res  in  1  reset, synchronous, active-low; sampled on rising clk.
- start  in  1  level-sampled; begin or restart a run with start_period.
- stop  in  1  level-sampled; abort any run and return to IDLE.
- mode  in  1  sampled with start: 0 = one-shot, 1 = periodic.
- start_period  in  8  period P for the run; 0 encodes 256.
- cfg_valid  in  1  new-period offer.
- cfg_period  in  8  offered period (0 = 256).
- cfg_ready  out  1  = !pend and res high; transfer on cfg_valid & cfg_ready at a rising edge.
- cnt  out  8  current count value.
- busy  out  1  high in RUN.
- tick  out  1  one-cycle registered pulse per terminal count.

## Operation
- States: IDLE, RUN. Internal registers: period_reg (8), mode_reg (1), shadow (8), pend (1).
- Terminal value term = period_reg - 1 (mod 256); P = 0 gives term 0xFF, P = 1 gives term 0x00.
- Edge priority, highest first: reset, stop, start, terminal, increment.
- Reset (res low at edge): state IDLE, cnt 0x00, period_reg 0x00, mode_reg 0, shadow 0x00, pend 0, tick 0, busy 0; cfg_ready low while res low.
- stop: state IDLE, cnt 0x00, pend 0, tick 0. Stop with start on the same edge means stop wins.
- start (from IDLE or RUN): state RUN, cnt 0x00, period_reg = start_period, mode_reg = mode, pend 0, tick 0. A restart in RUN never raises tick.
- RUN, cnt != term: cnt increments by 1.
- RUN, cnt == term, periodic: cnt 0x00, tick 1 next cycle. If pend is set, period_reg = shadow and pend clears.
- RUN, cnt == term, one-shot: state IDLE, cnt holds term (counter enable off), tick 1 next cycle, busy 0. pend is retained.
- IDLE: cnt holds its value, tick 0.
- cfg transfer: shadow = cfg_period, pend 1; legal in any state.
  - A transfer on the same edge as a periodic wrap does not affect that wrap. It applies at the following wrap.
  - A transfer on the same edge as start is discarded (pend ends at 0).
- Arithmetic: 8-bit unsigned, increment modulo 256; no carry out is exposed.

## Timing
- start sampled at edge N: busy = 1 and cnt = 0 after N; cnt = k after edge N+k.
- Periodic tick: first high in cycle after edge N+P; then every P cycles exactly.
- One-shot: tick high once in cycle after edge N+P; busy falls on that same edge.
- tick, busy, and cnt are registered. cfg_ready is combinational from pend and res only; no path from cfg_valid.
- Stop latency: one edge. tick is never high in the cycle after a stop edge.

## Structure
- Shared package timer8_pkg:
  - state enum (ST_IDLE, ST_RUN)
  - MODE_ONESHOT = 0, MODE_PERIODIC = 1
  - PERIOD_W = 8
- Sub-module cnt8_dp: 8-bit register with synchronous active-low reset, load (priority) of an 8-bit value, enable-gated +1 increment. It outputs the count. The controller drives load, load value (0x00), and enable.
- Controller (state, period/shadow/pend registers, terminal compare, tick register) lives in timer8_ctrl.

## Test plan
- Reset: hold res low 3 cycles with start = 1 and cfg_valid = 1 → cnt 0x00, busy 0, tick 0, cfg_ready 0. After release, cfg_ready 1.
- Periodic, P = 5: start with mode = 1 → cnt cycles 0,1,2,3,4,0…; tick high exactly at cycles N+5, N+10, N+15; busy stays 1.
- One-shot, P = 0 (256): → cnt reaches 0xFF and holds. A single tick occurs at N+256; busy drops at N+256.
- Period update:
  - Setup: periodic P = 4; cfg_period = 2 offered on the same edge as the first wrap.
  - Required: the next period is 4, then 2 thereafter; cfg_ready is low from transfer until the applying wrap.
- Collisions:
  - start and stop on one edge → IDLE, cnt 0.
  - Restart in RUN at cnt = 3 with P = 3 → cnt 0, no tick.
  - P = 1 periodic → tick high every cycle.
- Edge sequencing: stop on the terminal edge → no tick. Reset asserted mid-RUN → all outputs return to reset values next cycle.
